// File: rtl/rom.sv
// 16x4 read-only table, mem[a] = (7*a + 3) mod 16, with registered data/valid.
// Define ROM_PARITY_EN to add a registered even-parity output data_par.
module rom (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] addr,
  output logic [3:0] data,
  output logic       valid
`ifdef ROM_PARITY_EN
  ,
  output logic       data_par
`endif
);

  logic [3:0] rd;
  logic [3:0] nxt_data;
  logic       nxt_valid;

  always_comb begin
    rd = 4'h0;
    case (addr)
      4'h0: rd = 4'h3;
      4'h1: rd = 4'hA;
      4'h2: rd = 4'h1;
      4'h3: rd = 4'h8;
      4'h4: rd = 4'hF;
      4'h5: rd = 4'h6;
      4'h6: rd = 4'hD;
      4'h7: rd = 4'h4;
      4'h8: rd = 4'hB;
      4'h9: rd = 4'h2;
      4'hA: rd = 4'h9;
      4'hB: rd = 4'h0;
      4'hC: rd = 4'h7;
      4'hD: rd = 4'hE;
      4'hE: rd = 4'h5;
      4'hF: rd = 4'hC;
      default: rd = 4'h0;
    endcase
  end

  // Unknown address bits only exist in 4-state simulation; hardware always sees a real address.
  always_comb begin
    nxt_data  = rd;
    nxt_valid = 1'b1;
`ifndef SYNTHESIS
    if ($isunknown(addr)) begin
      nxt_data  = 4'h0;
      nxt_valid = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= 4'h0;
      valid <= 1'b0;
    end else if (en) begin
      data  <= nxt_data;
      valid <= nxt_valid;
    end else begin
      valid <= 1'b0;
    end
  end

`ifdef ROM_PARITY_EN
  // Loaded under the same condition as data so the two never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     data_par <= 1'b0;
    else if (en) data_par <= ^nxt_data;
  end
`endif

endmodule

// File: tb/tb_rom.sv
// Directed self-checking bench for rom; build with +define+ROM_PARITY_EN to cover data_par.
module tb_rom;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] addr;
  logic [3:0] data;
  logic       valid;
`ifdef ROM_PARITY_EN
  logic       data_par;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  rom dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .addr     (addr),
    .data     (data),
    .valid    (valid)
`ifdef ROM_PARITY_EN
    ,
    .data_par (data_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written contents: 3,A,1,8,F,6,D,4,B,2,9,0,7,E,5,C
  logic [3:0] exp_mem [16];
  initial begin
    exp_mem[0]  = 4'h3; exp_mem[1]  = 4'hA; exp_mem[2]  = 4'h1; exp_mem[3]  = 4'h8;
    exp_mem[4]  = 4'hF; exp_mem[5]  = 4'h6; exp_mem[6]  = 4'hD; exp_mem[7]  = 4'h4;
    exp_mem[8]  = 4'hB; exp_mem[9]  = 4'h2; exp_mem[10] = 4'h9; exp_mem[11] = 4'h0;
    exp_mem[12] = 4'h7; exp_mem[13] = 4'hE; exp_mem[14] = 4'h5; exp_mem[15] = 4'hC;
  end

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic tick(input logic e, input logic [3:0] a);
    en   = e;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1'b1, 4'h2);
    n_chk++; if (data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    rst = 1'b0;
    tick(1'b1, 4'h2);
    n_chk++; if (data !== 4'h1) begin n_fail++; $display("FAIL post_reset_data: got %h want 1", data); end
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid: got %b want 1", valid); end
  endtask

  task automatic test_read_seq;
    logic [3:0] a_v [4];
    logic [3:0] d_v [4];
    a_v[0] = 4'h2; a_v[1] = 4'hE; a_v[2] = 4'h8; a_v[3] = 4'hB;
    d_v[0] = 4'h1; d_v[1] = 4'h5; d_v[2] = 4'hB; d_v[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, a_v[i]);
      n_chk++; if (data !== d_v[i]) begin n_fail++; $display("FAIL seq_data[%0d]: got %h want %h", i, data, d_v[i]); end
      n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, valid); end
    end
  endtask

  task automatic test_enable_gating;
    tick(1'b0, 4'hF);
    n_chk++; if (data !== 4'h0) begin n_fail++; $display("FAIL gate_hold_data: got %h want 0", data); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL gate_valid: got %b want 0", valid); end
    tick(1'b1, 4'hE);
    n_chk++; if (data !== 4'h5) begin n_fail++; $display("FAIL gate_resume_data: got %h want 5", data); end
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL gate_resume_valid: got %b want 1", valid); end
  endtask

  task automatic test_boundaries;
    logic [3:0] probe;
    tick(1'b1, 4'h0);
    n_chk++; if (data !== 4'h3) begin n_fail++; $display("FAIL addr0: got %h want 3", data); end
    tick(1'b1, 4'hF);
    n_chk++; if (data !== 4'hC) begin n_fail++; $display("FAIL addrF: got %h want C", data); end
    tick(1'b1, 4'hA);
    n_chk++; if (data !== 4'h9) begin n_fail++; $display("FAIL addrA: got %h want 9", data); end
    // Unknown-address behaviour is only observable on a 4-state simulator.
    probe = 4'bxxxx;
    if ($isunknown(probe)) begin
      tick(1'b1, probe);
      n_chk++; if (data !== 4'h0) begin n_fail++; $display("FAIL xaddr_data: got %h want 0", data); end
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL xaddr_valid: got %b want 0", valid); end
    end
  endtask

  task automatic test_back_to_back;
    tick(1'b1, 4'h7);
    n_chk++; if (data !== 4'h4) begin n_fail++; $display("FAIL same_addr_1: got %h want 4", data); end
    tick(1'b1, 4'h7);
    n_chk++; if (data !== 4'h4) begin n_fail++; $display("FAIL same_addr_2: got %h want 4", data); end
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 4'(i));
      n_chk++;
      if (data !== exp_mem[i] || valid !== 1'b1) begin
        n_fail++; $display("FAIL sweep[%0d]: got %h/%b want %h/1", i, data, valid, exp_mem[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    tick(1'b1, 4'h4);
    n_chk++; if (data !== 4'hF) begin n_fail++; $display("FAIL pre_async_data: got %h want F", data); end
    en   = 1'b1;
    addr = 4'h3;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (data !== 4'h0) begin n_fail++; $display("FAIL async_data: got %h want 0", data); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", valid); end
    #1 rst = 1'b0;
    tick(1'b0, 4'h3);
    n_chk++; if (data !== 4'h0) begin n_fail++; $display("FAIL async_no_stale: got %h want 0", data); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL async_no_stale_valid: got %b want 0", valid); end
  endtask

`ifdef ROM_PARITY_EN
  task automatic test_parity;
    logic [3:0] a_v [4];
    logic [3:0] d_v [4];
    logic       p_v [4];
    a_v[0] = 4'h4; d_v[0] = 4'hF; p_v[0] = 1'b0;
    a_v[1] = 4'h1; d_v[1] = 4'hA; p_v[1] = 1'b0;
    a_v[2] = 4'h0; d_v[2] = 4'h3; p_v[2] = 1'b0;
    a_v[3] = 4'h2; d_v[3] = 4'h1; p_v[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, a_v[i]);
      n_chk++;
      if (data !== d_v[i] || data_par !== p_v[i]) begin
        n_fail++; $display("FAIL parity[%0d]: got %h/%b want %h/%b", i, data, data_par, d_v[i], p_v[i]);
      end
    end
    tick(1'b0, 4'hD);
    n_chk++; if (data_par !== 1'b1) begin n_fail++; $display("FAIL parity_hold: got %b want 1", data_par); end
  endtask
`endif

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    addr = 4'h0;
    test_reset();
    test_read_seq();
    test_enable_gating();
    test_boundaries();
    test_back_to_back();
    test_async_reset();
`ifdef ROM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
